// File: rtl/cache_pkg.sv
// Shared FSM encodings and address-field helpers for the write-through data cache.
package cache_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;

  localparam int unsigned BYTE_OFF_W = 2;
  localparam int unsigned BE_W       = 4;
  localparam int unsigned CNT_W      = 16;

  function automatic int unsigned off_width(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_width(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_width(input int unsigned width,
                                            input int unsigned sets,
                                            input int unsigned line_words);
    return width - $clog2(sets) - $clog2(line_words) - BYTE_OFF_W;
  endfunction

  // Extract a w-bit field starting at bit lsb of a (zero-extended) address.
  function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Tag, valid and data arrays of the direct-mapped cache: one lookup port,
// a refill word port, a byte-merge port gated by its own hit, and line validate.
module dcache_store
  import cache_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned OFF_W = off_width(LINE_WORDS),
  localparam int unsigned IDX_W = idx_width(SETS),
  localparam int unsigned TAG_W = tag_width(WIDTH, SETS, LINE_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [OFF_W-1:0] rd_off_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic [WIDTH-1:0] rd_data_c_o,
  output logic             rd_hit_c_o,
  input  logic             rf_we_i,
  input  logic [IDX_W-1:0] rf_idx_i,
  input  logic [OFF_W-1:0] rf_off_i,
  input  logic [WIDTH-1:0] rf_data_i,
  input  logic             mg_we_i,
  input  logic [IDX_W-1:0] mg_idx_i,
  input  logic [OFF_W-1:0] mg_off_i,
  input  logic [TAG_W-1:0] mg_tag_i,
  input  logic [WIDTH-1:0] mg_data_i,
  input  logic [BE_W-1:0]  mg_be_i,
  input  logic             val_we_i,
  input  logic [IDX_W-1:0] val_idx_i,
  input  logic [TAG_W-1:0] val_tag_i
);

  logic [WIDTH-1:0] data_q [SETS*LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [SETS-1:0]  valid_q;
  logic             mg_hit;

  assign rd_data_c_o = data_q[{rd_idx_i, rd_off_i}];
  assign rd_hit_c_o  = valid_q[rd_idx_i] & (tag_q[rd_idx_i] == rd_tag_i);

  // A store that misses leaves the line untouched (no write-allocate).
  assign mg_hit = mg_we_i & valid_q[mg_idx_i] & (tag_q[mg_idx_i] == mg_tag_i);

  always_ff @(posedge clk_i) begin
    if (rf_we_i) begin
      data_q[{rf_idx_i, rf_off_i}] <= rf_data_i;
    end else if (mg_hit) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (mg_be_i[b]) data_q[{mg_idx_i, mg_off_i}][8*b +: 8] <= mg_data_i[8*b +: 8];
      end
    end
    if (val_we_i) tag_q[val_idx_i] <= val_tag_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (val_we_i) begin
      valid_q[val_idx_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache: zero-stall read hits,
// line refill on read miss, every store forwarded to memory.
module dcache_wt
  import cache_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  input  logic [BE_W-1:0]  cpu_be,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [BE_W-1:0]  mem_be,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned OFF_W  = off_width(LINE_WORDS);
  localparam int unsigned IDX_W  = idx_width(SETS);
  localparam int unsigned TAG_W  = tag_width(WIDTH, SETS, LINE_WORDS);
  localparam int unsigned LINE_W = TAG_W + IDX_W;
  localparam int unsigned WADR_W = WIDTH - BYTE_OFF_W;

  logic [1:0]        state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [WADR_W-1:0] st_addr_q, st_addr_d;
  logic [WIDTH-1:0]  st_wdata_q, st_wdata_d;
  logic [BE_W-1:0]   st_be_q, st_be_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  miss_q, miss_d;

  logic [IDX_W-1:0]  cpu_idx;
  logic [OFF_W-1:0]  cpu_off;
  logic [TAG_W-1:0]  cpu_tag;
  logic              rd_hit;
  logic              rf_we, mg_we, val_we;

  assign cpu_off = OFF_W'(addr_field(64'(cpu_addr), BYTE_OFF_W, OFF_W));
  assign cpu_idx = IDX_W'(addr_field(64'(cpu_addr), BYTE_OFF_W + OFF_W, IDX_W));
  assign cpu_tag = TAG_W'(addr_field(64'(cpu_addr), BYTE_OFF_W + OFF_W + IDX_W, TAG_W));

  dcache_store #(
    .WIDTH      (WIDTH),
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_store (
    .clk_i       (CLK),
    .rst_i       (rst),
    .rd_idx_i    (cpu_idx),
    .rd_off_i    (cpu_off),
    .rd_tag_i    (cpu_tag),
    .rd_data_c_o (cpu_rdata),
    .rd_hit_c_o  (rd_hit),
    .rf_we_i     (rf_we),
    .rf_idx_i    (line_q[IDX_W-1:0]),
    .rf_off_i    (cnt_q),
    .rf_data_i   (mem_rdata),
    .mg_we_i     (mg_we),
    .mg_idx_i    (st_addr_q[OFF_W +: IDX_W]),
    .mg_off_i    (st_addr_q[OFF_W-1:0]),
    .mg_tag_i    (st_addr_q[OFF_W+IDX_W +: TAG_W]),
    .mg_data_i   (st_wdata_q),
    .mg_be_i     (st_be_q),
    .val_we_i    (val_we),
    .val_idx_i   (line_q[IDX_W-1:0]),
    .val_tag_i   (line_q[LINE_W-1:IDX_W])
  );

  // Memory interface is a pure decode of state and capture registers, so it holds until ack.
  assign mem_req   = (state_q == S_REFILL) | (state_q == S_WRITE);
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = (state_q == S_WRITE) ? {st_addr_q, 2'b00} : {line_q, cnt_q, 2'b00};
  assign mem_wdata = st_wdata_q;
  assign mem_be    = st_be_q;

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    st_addr_d  = st_addr_q;
    st_wdata_d = st_wdata_q;
    st_be_d    = st_be_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    cpu_stall  = 1'b0;
    rf_we      = 1'b0;
    mg_we      = 1'b0;
    val_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            cpu_stall  = 1'b1;
            st_addr_d  = cpu_addr[WIDTH-1:BYTE_OFF_W];
            st_wdata_d = cpu_wdata;
            st_be_d    = cpu_be;
            state_d    = S_WRITE;
          end else if (rd_hit) begin
            hit_d = hit_q + 16'd1;
          end else begin
            cpu_stall = 1'b1;
            miss_d    = miss_q + 16'd1;
            line_d    = cpu_addr[WIDTH-1:OFF_W+BYTE_OFF_W];
            cnt_d     = '0;
            state_d   = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        cpu_stall = 1'b1;
        if (mem_ack) begin
          rf_we = 1'b1;
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            val_we  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        cpu_stall = ~mem_ack;
        if (mem_ack) begin
          mg_we   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // The core must never see a stall while the cache is held in reset.
    if (rst) cpu_stall = 1'b0;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      line_q     <= '0;
      st_addr_q  <= '0;
      st_wdata_q <= '0;
      st_be_q    <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      st_addr_q  <= st_addr_d;
      st_wdata_q <= st_wdata_d;
      st_be_q    <= st_be_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: directed scenarios plus random loads/stores
// against a set/tag/memory reference model and a latency-randomising memory.
module tb_dcache_wt;

  localparam int unsigned SETS       = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LINE_BYTES = LINE_WORDS * 4;

  logic        CLK, rst, cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be, mem_be;
  logic        cpu_stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] hit_count, miss_count;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  req_t        log_q[$];
  logic [31:0] mem [logic [31:0]];
  bit          m_valid [SETS];
  int unsigned m_tag   [SETS];
  int unsigned m_hits, m_misses;
  int          n_checks, n_fail;
  int          ack_delay, delay_sum, ack_total;
  bit          force_ack;
  int          last_stall, last_acks;
  logic [31:0] last_rdata;

  dcache_wt #(.WIDTH(32), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_be     (cpu_be),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic bit model_lookup(input logic [31:0] a);
    int unsigned line;
    line = a / LINE_BYTES;
    return m_valid[line % SETS] && (m_tag[line % SETS] == line / SETS);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < int'(SETS); s++) m_valid[s] = 1'b0;
    m_hits = 0;
    m_misses = 0;
  endtask

  // Memory: ack after ack_delay request cycles (random 1..3 when 0); records each request.
  initial begin
    int          cyc;
    int          cur_delay;
    logic [31:0] req_addr, w;
    mem_ack = 1'b0;
    mem_rdata = '0;
    cyc = 0;
    cur_delay = 1;
    req_addr = '0;
    forever begin
      @(posedge CLK);
      #2;
      mem_ack = 1'b0;
      if (rst) begin
        cyc = 0;
      end else if (mem_req) begin
        if (cyc == 0) begin
          req_addr  = mem_addr;
          cur_delay = (ack_delay == 0) ? int'($urandom_range(1, 3)) : ack_delay;
        end
        cyc++;
        if (cyc >= cur_delay) begin
          check("mem_addr_stable", mem_addr, req_addr);
          log_q.push_back('{mem_we, mem_addr, mem_wdata, mem_be});
          if (mem_we) begin
            w = mem_rd(mem_addr);
            for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[mem_addr] = w;
          end else begin
            mem_rdata = mem_rd(mem_addr);
          end
          mem_ack = 1'b1;
          ack_total++;
          delay_sum += cur_delay;
          cyc = 0;
        end
      end else begin
        cyc = 0;
        if (force_ack) begin
          mem_ack = 1'b1;
          force_ack = 1'b0;
        end
      end
    end
  end

  task automatic do_op(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    int a0;
    @(posedge CLK);
    #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_be = be;
    delay_sum = 0;
    a0 = ack_total;
    last_stall = 0;
    forever begin
      @(negedge CLK);
      if (!cpu_stall) break;
      last_stall++;
      if (last_stall > 200) begin
        check("op_timeout", 64'(last_stall), 64'd0);
        break;
      end
    end
    last_rdata = cpu_rdata;
    @(posedge CLK);
    #1;
    cpu_req = 1'b0;
    last_acks = ack_total - a0;
  endtask

  task automatic run_load(input logic [31:0] a, input string tag);
    bit          hit;
    int unsigned line;
    hit = model_lookup(a);
    do_op(1'b0, a, 32'h0, 4'h0);
    line = a / LINE_BYTES;
    check({tag, "_stall"}, 64'(last_stall), hit ? 64'd0 : 64'(delay_sum + 1));
    check({tag, "_acks"}, 64'(last_acks), hit ? 64'd0 : 64'(LINE_WORDS));
    check({tag, "_rdata"}, last_rdata, mem_rd(a & 32'hFFFF_FFFC));
    if (!hit) begin
      m_misses++;
      m_valid[line % SETS] = 1'b1;
      m_tag[line % SETS]   = line / SETS;
    end
    m_hits++;
    check({tag, "_hits"}, hit_count, 16'(m_hits));
    check({tag, "_misses"}, miss_count, 16'(m_misses));
  endtask

  task automatic run_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be, input string tag);
    int n0;
    n0 = log_q.size();
    do_op(1'b1, a, wd, be);
    check({tag, "_stall"}, 64'(last_stall), 64'(delay_sum));
    check({tag, "_reqs"}, 64'(log_q.size()), 64'(n0 + 1));
    if (log_q.size() > 0) begin
      check({tag, "_mem_we"}, log_q[$].we, 1'b1);
      check({tag, "_mem_addr"}, log_q[$].addr, a & 32'hFFFF_FFFC);
      check({tag, "_mem_wdata"}, log_q[$].wdata, wd);
      check({tag, "_mem_be"}, log_q[$].be, be);
    end
    check({tag, "_hits"}, hit_count, 16'(m_hits));
    check({tag, "_misses"}, miss_count, 16'(m_misses));
  endtask

  initial begin
    logic [31:0] a;
    int          a0, waited;
    int unsigned m0;
    n_checks = 0; n_fail = 0; ack_total = 0; delay_sum = 0; ack_delay = 0;
    force_ack = 1'b0;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    mem[32'h100] = 32'h11; mem[32'h104] = 32'h22; mem[32'h108] = 32'h33; mem[32'h10C] = 32'h44;
    model_reset();

    repeat (3) @(posedge CLK);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_hits", hit_count, 16'd0);
    check("rst_misses", miss_count, 16'd0);
    rst = 1'b0;

    // Load miss then hit, fixed 2-cycle memory.
    ack_delay = 2;
    run_load(32'h104, "t1_miss");
    check("t1_stall9", 64'(last_stall), 64'd9);
    check("t1_data", last_rdata, 32'h22);
    check("t1_cnt", {hit_count, miss_count}, {16'd1, 16'd1});
    run_load(32'h10C, "t1_hit");
    check("t1_hit_data", last_rdata, 32'h44);

    // Store hit merges only enabled lanes.
    ack_delay = 1;
    run_store(32'h104, 32'hAABBCCDD, 4'b0011, "t2_st");
    check("t2_ack1_stall", 64'(last_stall), 64'd1);
    run_load(32'h104, "t2_ld");
    check("t2_merged", last_rdata, 32'h0000CCDD);

    // Store miss does not allocate.
    ack_delay = 0;
    run_store(32'h2000, 32'h12345678, 4'hF, "t3_st");
    run_load(32'h2000, "t3_ld");
    check("t3_refilled", 64'(last_acks), 64'(LINE_WORDS));

    // Conflict eviction on one set.
    m0 = m_misses;
    run_load(32'h100, "t4_a");
    run_load(32'h100 + SETS * LINE_BYTES, "t4_b");
    run_load(32'h100, "t4_c");
    check("t4_misses3", miss_count, 16'(m0 + 3));

    // Reset after the second refill ack.
    ack_delay = 2;
    @(posedge CLK);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
    a0 = ack_total;
    waited = 0;
    while ((ack_total - a0) < 2 && waited < 100) begin
      @(posedge CLK);
      waited++;
    end
    check("t5_two_acks", 64'(ack_total - a0), 64'd2);
    #1;
    rst = 1'b1;
    #1;
    check("t5_mem_req", mem_req, 1'b0);
    check("t5_stall", cpu_stall, 1'b0);
    cpu_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b0;
    model_reset();
    run_load(32'h300, "t5_reload");

    // Stray ack while idle is ignored.
    @(posedge CLK);
    #1;
    force_ack = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("t6_mem_req", mem_req, 1'b0);
    check("t6_stall", cpu_stall, 1'b0);
    check("t6_cnt", {hit_count, miss_count}, {16'(m_hits), 16'(m_misses)});
    run_load(32'h300, "t6_hit");

    // Random loads/stores over 4 tags so sets conflict.
    ack_delay = 0;
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 3) run_store(a, $urandom, 4'($urandom_range(0, 15)), "rnd_st");
      else run_load(a, "rnd_ld");
    end

    // Hit counter wraps after 65536 hits.
    @(posedge CLK);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b0;
    model_reset();
    run_load(32'h100, "t7_first");
    @(posedge CLK);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    repeat (65535) @(posedge CLK);
    #1;
    cpu_req = 1'b0;
    m_hits += 65535;
    @(negedge CLK);
    check("t7_wrap_hits", hit_count, 16'(m_hits));
    check("t7_wrap_zero", hit_count, 16'd0);
    check("t7_wrap_misses", miss_count, 16'(m_misses));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
